// File: rtl/cache_bram_ctrl.sv
// Port controller for one simple-dual-port cache BRAM: clears the array after reset or on request,
// arbitrates refill/store writes on port A, and sequences port-B reads with write-to-read bypass.
module cache_bram_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_init_req,
  output logic                 o_busy,
  output logic                 o_init_done,
  input  logic                 i_rf_valid,
  output logic                 o_rf_ready,
  input  logic [ADDR_SIZE-1:0] i_rf_addr,
  input  logic [DATA_SIZE-1:0] i_rf_data,
  input  logic                 i_st_valid,
  output logic                 o_st_ready,
  input  logic [ADDR_SIZE-1:0] i_st_addr,
  input  logic [DATA_SIZE-1:0] i_st_data,
  input  logic [3:0]           i_st_strb,
  input  logic                 i_rd_valid,
  output logic                 o_rd_ready,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic                 o_rd_rvalid,
  output logic [DATA_SIZE-1:0] o_rd_rdata,
  output logic                 o_ena,
  output logic [3:0]           o_wea,
  output logic [ADDR_SIZE-1:0] o_addra,
  output logic [DATA_SIZE-1:0] o_dina,
  output logic                 o_enb,
  output logic [ADDR_SIZE-1:0] o_addrb,
  input  logic [DATA_SIZE-1:0] i_doutb
);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic [2:0]           r_starve;
  logic                 r_busy;
  logic                 r_init_done;
  logic                 r_rvalid;
  logic [DATA_SIZE-1:0] r_byp_data;
  logic [DATA_SIZE-1:0] r_byp_mask;

  logic                 w_idle;
  logic                 w_st_prio;
  logic                 w_gnt_rf;
  logic                 w_gnt_st;
  logic                 w_rd_acc;
  logic [DATA_SIZE-1:0] w_mask;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_st_prio  = (r_starve == 3'd4);
  assign o_rf_ready = w_idle && !(i_st_valid && w_st_prio);
  assign o_st_ready = w_idle && (!i_rf_valid || w_st_prio);
  assign w_gnt_rf   = i_rf_valid && o_rf_ready;
  assign w_gnt_st   = i_st_valid && o_st_ready;
  assign o_rd_ready = w_idle;
  assign w_rd_acc   = i_rd_valid && w_idle;

  assign o_enb       = w_rd_acc;
  assign o_addrb     = i_rd_addr;
  assign o_busy      = r_busy;
  assign o_init_done = r_init_done;
  assign o_rd_rvalid = r_rvalid;

  // Merge the same-cycle write over the BRAM's read-old-data output.
  assign o_rd_rdata = r_rvalid ? ((r_byp_data & r_byp_mask) | (i_doutb & ~r_byp_mask)) : '0;

  always_comb begin
    o_ena   = 1'b0;
    o_wea   = '0;
    o_addra = '0;
    o_dina  = '0;
    if (!w_idle) begin
      o_ena   = 1'b1;
      o_wea   = '1;
      o_addra = r_cnt;
    end else if (w_gnt_rf) begin
      o_ena   = 1'b1;
      o_wea   = '1;
      o_addra = i_rf_addr;
      o_dina  = i_rf_data;
    end else if (w_gnt_st) begin
      o_ena   = 1'b1;
      o_wea   = i_st_strb;
      o_addra = i_st_addr;
      o_dina  = i_st_data;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      w_mask[b*8 +: 8] = {8{o_wea[b]}};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_rvalid    <= 1'b0;
      r_byp_data  <= '0;
      r_byp_mask  <= '0;
    end else begin
      r_init_done <= 1'b0;
      r_rvalid    <= w_rd_acc;
      r_byp_data  <= o_dina;
      if (w_rd_acc && (w_gnt_rf || w_gnt_st) && (o_addra == i_rd_addr)) begin
        r_byp_mask <= w_mask;
      end else begin
        r_byp_mask <= '0;
      end

      if (w_gnt_rf && i_st_valid) begin
        r_starve <= r_starve + 3'd1;
      end else if (w_gnt_st || !i_st_valid) begin
        r_starve <= '0;
      end

      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_init_req) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bram_ctrl.sv
// Bench for cache_bram_ctrl: BRAM behavioural model, reference model of memory contents and
// arbitration checked every cycle, plus directed scenarios with literal expectations.
module tb_cache_bram_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req = 1'b0;
  logic          busy, init_done;
  logic          rf_valid = 1'b0, rf_ready;
  logic [AW-1:0] rf_addr = '0;
  logic [DW-1:0] rf_data = '0;
  logic          st_valid = 1'b0, st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [3:0]    st_strb = '0;
  logic          rd_valid = 1'b0, rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          ena, enb;
  logic [3:0]    wea;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, doutb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_bram_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_req(init_req), .o_busy(busy), .o_init_done(init_done),
    .i_rf_valid(rf_valid), .o_rf_ready(rf_ready), .i_rf_addr(rf_addr), .i_rf_data(rf_data),
    .i_st_valid(st_valid), .o_st_ready(st_ready), .i_st_addr(st_addr), .i_st_data(st_data),
    .i_st_strb(st_strb), .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
    .o_rd_rvalid(rd_rvalid), .o_rd_rdata(rd_rdata), .o_ena(ena), .o_wea(wea), .o_addra(addra),
    .o_dina(dina), .o_enb(enb), .o_addrb(addrb), .i_doutb(doutb)
  );

  // BRAM: registered read, read-old-data on same-edge collision, byte-enabled write
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
    if (ena) for (int b = 0; b < 4; b++) if (wea[b]) mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: clearing flag/index, consecutive refill wins over a waiting store, memory image.
  bit            m_clr = 1'b1;
  int            m_idx = 0;
  int            m_starve = 0;
  bit            m_done = 1'b0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rexp = '0;
  logic [DW-1:0] gmem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) gmem[i] = '0;

  bit            g_rf, g_st, e_rfr, e_str;
  bit            e_ena;
  logic [3:0]    e_wea;
  logic [AW-1:0] e_addra;
  logic [DW-1:0] e_dina;

  always @(negedge clk) begin
    if (rst) begin
      m_clr = 1'b1; m_idx = 0; m_starve = 0; m_done = 1'b0; m_rv = 1'b0;
    end
    e_rfr = !m_clr && !(st_valid && m_starve == 4);
    e_str = !m_clr && (!rf_valid || m_starve == 4);
    g_st  = st_valid && e_str;
    g_rf  = rf_valid && e_rfr;
    if (m_clr) begin
      e_ena = 1'b1; e_wea = 4'hf; e_addra = AW'(m_idx); e_dina = '0;
    end else if (g_rf) begin
      e_ena = 1'b1; e_wea = 4'hf; e_addra = rf_addr; e_dina = rf_data;
    end else if (g_st) begin
      e_ena = 1'b1; e_wea = st_strb; e_addra = st_addr; e_dina = st_data;
    end else begin
      e_ena = 1'b0; e_wea = '0; e_addra = '0; e_dina = '0;
    end

    chk("busy", busy, m_clr);
    chk("init_done", init_done, m_done);
    chk("readies", {rf_ready, st_ready, rd_ready}, {e_rfr, e_str, !m_clr});
    chk("ena_wea", {ena, wea}, {e_ena, e_wea});
    if (e_ena) chk("addra_dina", {addra, dina}, {e_addra, e_dina});
    chk("enb", enb, !m_clr && rd_valid);
    if (!m_clr && rd_valid) chk("addrb", addrb, rd_addr);
    chk("rvalid", rd_rvalid, m_rv);
    if (m_rv) chk("rdata", rd_rdata, m_rexp);

    if (!rst) begin
      if (e_ena) for (int b = 0; b < 4; b++)
        if (e_wea[b]) gmem[e_addra][b*8 +: 8] = e_dina[b*8 +: 8];
      if (m_clr) begin
        m_rv = 1'b0;
        if (m_idx == DEPTH - 1) begin m_clr = 1'b0; m_done = 1'b1; end
        else m_idx++;
      end else begin
        m_done = 1'b0;
        m_rv   = rd_valid;
        if (rd_valid) m_rexp = gmem[rd_addr];
        if (init_req) begin m_clr = 1'b1; m_idx = 0; end
      end
      if (g_rf && st_valid) m_starve++;
      else if (g_st || !st_valid) m_starve = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles until the first idle cycle, then pins the done pulse and its length.
  task automatic wait_clear(input string nm, input int n0);
    int n;
    bit seen;
    n = n0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) n++;
      else begin seen = 1'b1; break; end
    end
    chk({nm, "_finished"}, seen, 1'b1);
    chk({nm, "_len"}, n, 128);
    chk({nm, "_done_pulse"}, init_done, 1'b1);
    @(negedge clk);
    chk({nm, "_done_single"}, init_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    step();
    @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_rdy", {rf_ready, st_ready, rd_ready, rd_rvalid, enb}, 5'b0);
    chk("rst_porta", {ena, wea, addra}, {1'b1, 4'hf, 7'd0});
    step();
    rst = 1'b0;
    wait_clear("clr0", 0);

    // refill then read next cycle
    step();
    rf_valid = 1'b1; rf_addr = 7'h12; rf_data = 32'hDEADBEEF;
    step();
    rf_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7'h12;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("rf_rd_valid", rd_rvalid, 1'b1);
    chk("rf_rd_data", rd_rdata, 32'hDEADBEEF);

    // partial store with same-cycle read bypass
    step();
    rf_valid = 1'b1; rf_addr = 7'h05; rf_data = 32'h11223344;
    step();
    rf_valid = 1'b0;
    st_valid = 1'b1; st_addr = 7'h05; st_strb = 4'b0011; st_data = 32'hAAAA5555;
    rd_valid = 1'b1; rd_addr = 7'h05;
    step();
    st_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    chk("bypass", rd_rdata, 32'h11225555);
    step();
    rd_valid = 1'b1; rd_addr = 7'h05;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("store_readback", rd_rdata, 32'h11225555);

    // both writers held: 4 refills then 1 store, repeating
    step();
    rf_valid = 1'b1; st_valid = 1'b1; st_strb = 4'hf;
    for (int i = 0; i < 20; i++) begin
      rf_addr = AW'(8'h40 + i); rf_data = 32'h1000 + i;
      st_addr = AW'(8'h60 + i); st_data = 32'h2000 + i;
      @(negedge clk);
      chk("arb_st", st_ready, (i % 5) == 4);
      chk("arb_rf", rf_ready, (i % 5) != 4);
      step();
    end
    rf_valid = 1'b0; st_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 7'h40;
    step();
    rd_addr = 7'h64;
    @(negedge clk);
    chk("arb_rd_rf0", rd_rdata, 32'h1000);
    step();
    rd_addr = 7'h44;
    @(negedge clk);
    chk("arb_rd_st4", rd_rdata, 32'h2004);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("arb_rd_skipped", rd_rdata, 32'h0);

    // init_req during streaming traffic
    step();
    rf_valid = 1'b1; rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rf_addr = AW'(8'h20 + i); rf_data = 32'h3000 + i; rd_addr = AW'(8'h20 + i);
      step();
    end
    init_req = 1'b1; rf_addr = 7'h30; rd_addr = 7'h12;
    step();
    init_req = 1'b0;
    @(negedge clk);
    chk("ireq_stop", {rf_ready, rd_ready, busy}, 3'b001);
    chk("ireq_last_rd", rd_rdata, 32'hDEADBEEF);
    wait_clear("clr_req", 1);
    step();
    rf_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7'h12;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("post_clear_rd", rd_rdata, 32'h0);

    // reset in the middle of a clear
    step();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (addra == 7'd60) begin found = 1'b1; break; end
    end
    chk("reach_cnt60", found, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_addra", {busy, addra}, {1'b1, 7'd0});
    step();
    step();
    rst = 1'b0;
    wait_clear("clr_rst", 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_bram_ctrl.md
# cache_bram_ctrl

Port controller for one cache simple-dual-port BRAM (port A write with 4-bit byte enables, port B read, 1-cycle registered read, read-old-data on same-edge collision). It clears the array after reset or on request, arbitrates the single write port between the refill engine and the store path, and sequences reads with same-cycle write-to-read bypass. It sits between the cache pipeline and each data/tag BRAM instance.

## Interface

- DATA_SIZE, 32, word width (byte enables assume 32)
- ADDR_SIZE, 7, address width; depth = 2**ADDR_SIZE
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- init_req  in  1  request full-array clear
- busy  out  1  high while clearing
- init_done  out  1  one-cycle pulse when a clear finishes
- rf_valid / rf_ready  in / out  1 / 1  refill write handshake
- rf_addr, rf_data  in  ADDR_SIZE, DATA_SIZE  refill word (full-word write)
- st_valid / st_ready  in / out  1 / 1  store write handshake
- st_addr, st_data, st_strb  in  ADDR_SIZE, DATA_SIZE, 4  store word and byte strobes
- rd_valid / rd_ready  in / out  1 / 1  read request handshake
- rd_addr  in  ADDR_SIZE  read address
- rd_rvalid, rd_rdata  out  1, DATA_SIZE  read response
- ena, wea, addra, dina  out  1, 4, ADDR_SIZE, DATA_SIZE  BRAM port A
- enb, addrb  out  1, ADDR_SIZE  BRAM port B
- doutb  in  DATA_SIZE  BRAM read data

## Operation

- States: INIT, IDLE. Reset state INIT, clear counter = 0.
- INIT: each cycle ena=1, wea=4'hf, addra=counter, dina=0; counter++. On the cycle with counter = 2**ADDR_SIZE-1, next state IDLE. All readies 0, busy=1. init_req ignored.
- IDLE: busy=0. init_req=1 -> next state INIT, counter=0; requests handshaken in that same cycle still complete.
- Write arbitration (IDLE only, ready combinational from valid): refill wins by default. starve counter (3 bits) increments when refill granted while st_valid=1; clears when store granted or st_valid=0. When starve=4 and both valid, store granted, refill not ready. At most one grant per cycle.
- Refill grant: ena=1, wea=4'hf, addra=rf_addr, dina=rf_data. Store grant: ena=1, wea=st_strb, addra=st_addr, dina=st_data; st_strb=0 is accepted but writes nothing. No grant: ena=0, wea=0.
- Reads: rd_ready = (state==IDLE), independent of writes. Accept -> enb=1, addrb=rd_addr that cycle.
- Bypass: if a write is granted in the same cycle as an accepted read and addra==rd_addr, register the write data and byte mask; in the response cycle rd_rdata = (wdata&mask)|(doutb&~mask). Otherwise rd_rdata = doutb.

## Timing

- Reset values (while rst high): state INIT, counter 0, busy=1, init_done=0, rf_ready=st_ready=rd_ready=0, rd_rvalid=0, rd_rdata=0, starve=0; port A shows the zero write to address 0 (harmless), enb=0.
- Clear length: exactly 2**ADDR_SIZE cycles (128 default); init_done=1 in first IDLE cycle, busy falls same cycle.
- Write commits at the rising edge ending its grant cycle.
- Read latency: accept in cycle N -> rd_rvalid=1 and data in N+1; one read per cycle, back-to-back allowed; no backpressure on response.
- Read accepted in the cycle init_req is seen returns in the first INIT cycle with correct data.
- rst mid-clear restarts clear from address 0; in-flight read response is dropped.

## Test plan

- Reset release -> busy high 128 cycles, addra 0..127 with dina 0, init_done single pulse at cycle 128, readies rise.
- Refill write 0x12 <= 0xDEADBEEF, read 0x12 next cycle -> rd_rdata 0xDEADBEEF one cycle after accept.
- Store 0x05 strb 4'b0011 data 0xAAAA5555 over 0x11223344, read 0x05 same cycle -> bypass gives 0x11225555; read again later -> 0x11225555.
- rf_valid and st_valid held high continuously -> grant pattern 4 refill, 1 store repeating.
- init_req while reads/writes streaming -> handshakes stop next cycle, 128-cycle clear, later reads return 0.
- rst asserted at clear counter 60 -> counter 0, clear restarts, full 128 cycles before init_done.
